reg_delay_line: RTL and testbench

Parametrised registered delay line: WIDTH-bit data plus a valid flag pass through DEPTH flip-flop stages, with clock enable (stall), synchronous clear and a run-time tap select. It generalises the team's single-stage 8-bit DFF into a multi-stage, multi-width pipeline register. It is used wherever a datapath needs a fixed or programmable latency match. A registered occupancy count reports how many valid words are in flight.

---
 rtl/reg_delay_line_if.sv | 30 +++
 rtl/reg_delay_line.sv | 100 ++++++++++
 tb/tb_reg_delay_line.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_delay_line_if.sv
// Bus bundle for reg_delay_line: control/data inputs on the master side,
// tap, last-stage and occupancy outputs on the slave side.
interface reg_delay_line_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic             en;
    logic             clr;
    logic [WIDTH-1:0] d_in;
    logic             vld_in;
    logic [SW-1:0]    sel;
    logic [WIDTH-1:0] q;
    logic             vld_out;
    logic [WIDTH-1:0] q_last;
    logic             vld_last;
    logic [CW-1:0]    cnt;

    modport master (
        output en, clr, d_in, vld_in, sel,
        input  q, vld_out, q_last, vld_last, cnt
    );

    modport slave (
        input  en, clr, d_in, vld_in, sel,
        output q, vld_out, q_last, vld_last, cnt
    );
endinterface

// File: rtl/reg_delay_line.sv
// Registered delay line: DEPTH stages of WIDTH-bit data plus valid, with stall,
// synchronous clear, a clamped run-time output tap and a live occupancy count.
module reg_delay_line #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic            clk,
    input  logic            rst,
    reg_delay_line_if.slave bus
);
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] s_vec;
    logic [DEPTH-1:0]            v_vec;
    logic [CW-1:0]               cnt_reg;
    logic [CW-1:0]               cnt_next;
    logic [SW-1:0]               tap;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] s_reg;
            logic [WIDTH-1:0] s_next;
            logic [WIDTH-1:0] s_src;
            logic             v_reg;
            logic             v_next;
            logic             v_src;

            if (gi == 0) begin : g_head
                assign s_src = bus.d_in;
                assign v_src = bus.vld_in;
            end else begin : g_body
                assign s_src = s_vec[gi-1];
                assign v_src = v_vec[gi-1];
            end

            // Data moves even when its valid bit is low: no bubble collapsing.
            always_comb begin
                s_next = s_reg;
                v_next = v_reg;
                if (bus.clr) begin
                    s_next = RST_VAL;
                    v_next = 1'b0;
                end else if (bus.en) begin
                    s_next = s_src;
                    v_next = v_src;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s_reg <= RST_VAL;
                    v_reg <= 1'b0;
                end else begin
                    s_reg <= s_next;
                    v_reg <= v_next;
                end
            end

            assign s_vec[gi] = s_reg;
            assign v_vec[gi] = v_reg;
        end
    endgenerate

    // One word in, one word out per enabled edge: count moves only when they differ.
    always_comb begin
        cnt_next = cnt_reg;
        if (bus.clr) begin
            cnt_next = '0;
        end else if (bus.en) begin
            if (bus.vld_in && !v_vec[DEPTH-1]) begin
                cnt_next = cnt_reg + CW'(1);
            end else if (!bus.vld_in && v_vec[DEPTH-1]) begin
                cnt_next = cnt_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    always_comb begin
        tap = bus.sel;
        if (int'(bus.sel) > DEPTH - 1) begin
            tap = SW'(DEPTH - 1);
        end
    end

    assign bus.q        = s_vec[tap];
    assign bus.vld_out  = v_vec[tap];
    assign bus.q_last   = s_vec[DEPTH-1];
    assign bus.vld_last = v_vec[DEPTH-1];
    assign bus.cnt      = cnt_reg;
endmodule

// File: tb/tb_reg_delay_line.sv
// Self-checking bench for reg_delay_line: a 4-deep instance tracked by a
// scoreboard queue, plus a 3-deep instance for tap clamping and reset value.
module tb_reg_delay_line;
    localparam int         DEPTH = 4;
    localparam logic [7:0] RST4  = 8'h00;
    localparam logic [7:0] RST3  = 8'h5A;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_delay_line_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
    reg_delay_line_if #(.WIDTH(8), .DEPTH(3)) bus3 ();

    reg_delay_line #(.WIDTH(8), .DEPTH(4), .RST_VAL(RST4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );
    reg_delay_line #(.WIDTH(8), .DEPTH(3), .RST_VAL(RST3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    int errors = 0;
    int checks = 0;

    // Scoreboard: sb[0] is the word expected at the final stage, sb[DEPTH-1] at stage 0.
    logic [8:0] sb [$];

    task automatic sb_clear();
        sb.delete();
        for (int i = 0; i < DEPTH; i++) sb.push_back({1'b0, RST4});
    endtask

    function automatic logic [8:0] tap_exp(input int n);
        return sb[DEPTH-1-n];
    endfunction

    function automatic int cnt_exp();
        int c = 0;
        foreach (sb[i]) c += int'(sb[i][8]);
        return c;
    endfunction

    task automatic step(input logic e, input logic c, input logic [7:0] d, input logic v);
        bus4.en = e; bus4.clr = c; bus4.d_in = d; bus4.vld_in = v;
        @(posedge clk); #1;
        if (c) begin
            sb_clear();
        end else if (e) begin
            sb.push_back({v, d});
            void'(sb.pop_front());
        end
        bus4.en = 1'b0; bus4.clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        rst = 1'b0; bus4.sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            bus4.en = 1'b1; bus4.vld_in = 1'b1; bus4.d_in = 8'($urandom);
            @(posedge clk); #1;
            checks++; if (bus4.q !== RST4) begin errors++; $display("FAIL rst_q cyc%0d: got %h want %h", i, bus4.q, RST4); end
            checks++; if (bus4.q_last !== RST4) begin errors++; $display("FAIL rst_q_last cyc%0d: got %h want %h", i, bus4.q_last, RST4); end
            checks++; if (bus4.vld_out !== 1'b0 || bus4.vld_last !== 1'b0) begin errors++; $display("FAIL rst_vld cyc%0d: got %b/%b want 0/0", i, bus4.vld_out, bus4.vld_last); end
            checks++; if (bus4.cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt cyc%0d: got %0d want 0", i, bus4.cnt); end
            checks++; if (bus3.q_last !== RST3) begin errors++; $display("FAIL rst_q_last_d3 cyc%0d: got %h want %h", i, bus3.q_last, RST3); end
        end
        bus4.en = 1'b0;
        rst = 1'b1;
        sb_clear();
        step(1'b1, 1'b0, 8'hA5, 1'b1);
        e = tap_exp(0);
        checks++; if (bus4.q !== 8'hA5 || bus4.q !== e[7:0]) begin errors++; $display("FAIL first_q: got %h want a5", bus4.q); end
        checks++; if (bus4.vld_out !== 1'b1) begin errors++; $display("FAIL first_vld: got %b want 1", bus4.vld_out); end
        checks++; if (bus4.cnt !== 3'd1) begin errors++; $display("FAIL first_cnt: got %0d want 1", bus4.cnt); end
    endtask

    task automatic test_midstream_reset();
        step(1'b1, 1'b0, 8'h10, 1'b1);
        step(1'b1, 1'b0, 8'h20, 1'b1);
        checks++; if (int'(bus4.cnt) !== cnt_exp()) begin errors++; $display("FAIL mrst_pre_cnt: got %0d want %0d", bus4.cnt, cnt_exp()); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus4.cnt !== 3'd0) begin errors++; $display("FAIL mrst_async_cnt: got %0d want 0", bus4.cnt); end
        checks++; if (bus4.q !== RST4 || bus4.vld_out !== 1'b0) begin errors++; $display("FAIL mrst_async_tap0: got %h/%b want %h/0", bus4.q, bus4.vld_out, RST4); end
        bus4.en = 1'b1; bus4.vld_in = 1'b1; bus4.d_in = 8'h77;
        @(posedge clk); #1;
        checks++; if (bus4.vld_out !== 1'b0 || bus4.cnt !== 3'd0) begin errors++; $display("FAIL mrst_hold: got vld %b cnt %0d want 0/0", bus4.vld_out, bus4.cnt); end
        rst = 1'b1;
        bus4.en = 1'b0;
        sb_clear();
        step(1'b1, 1'b0, 8'h3C, 1'b1);
        bus4.sel = 2'd0; #1;
        checks++; if (bus4.q !== 8'h3C || bus4.vld_out !== 1'b1) begin errors++; $display("FAIL mrst_reload_s0: got %h/%b want 3c/1", bus4.q, bus4.vld_out); end
        bus4.sel = 2'd1; #1;
        checks++; if (bus4.vld_out !== 1'b0 || bus4.q !== RST4) begin errors++; $display("FAIL mrst_reload_s1: got %h/%b want %h/0", bus4.q, bus4.vld_out, RST4); end
        checks++; if (bus4.cnt !== 3'd1) begin errors++; $display("FAIL mrst_reload_cnt: got %0d want 1", bus4.cnt); end
    endtask

    task automatic test_latency();
        logic [8:0] e;
        step(1'b0, 1'b1, 8'h00, 1'b0);
        bus4.sel = 2'd3;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b1);
            e = tap_exp(3);
            checks++; if (bus4.q !== e[7:0] || bus4.vld_out !== e[8]) begin errors++; $display("FAIL lat_q edge%0d: got %h/%b want %h/%b", i, bus4.q, bus4.vld_out, e[7:0], e[8]); end
            checks++; if (bus4.q_last !== e[7:0] || bus4.vld_last !== e[8]) begin errors++; $display("FAIL lat_q_last edge%0d: got %h/%b want %h/%b", i, bus4.q_last, bus4.vld_last, e[7:0], e[8]); end
            checks++; if (int'(bus4.cnt) !== ((i < 4) ? i : 4)) begin errors++; $display("FAIL lat_cnt edge%0d: got %0d want %0d", i, bus4.cnt, (i < 4) ? i : 4); end
            if (i == 4) begin
                checks++; if (bus4.q !== 8'h01) begin errors++; $display("FAIL lat_first_word: got %h want 01", bus4.q); end
            end
        end
    endtask

    task automatic test_stall();
        logic [8:0] e;
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h11, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b1);
        step(1'b1, 1'b0, 8'h33, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 8'($urandom), 1'($urandom));
            checks++; if (bus4.cnt !== 3'd3) begin errors++; $display("FAIL stall_cnt cyc%0d: got %0d want 3", c, bus4.cnt); end
            for (int t = 0; t < DEPTH; t++) begin
                bus4.sel = 2'(t); #1;
                e = tap_exp(t);
                checks++; if (bus4.q !== e[7:0] || bus4.vld_out !== e[8]) begin errors++; $display("FAIL stall_tap%0d cyc%0d: got %h/%b want %h/%b", t, c, bus4.q, bus4.vld_out, e[7:0], e[8]); end
            end
        end
        step(1'b1, 1'b0, 8'h44, 1'b1);
        step(1'b1, 1'b0, 8'h55, 1'b1);
        checks++; if (bus4.q_last !== 8'h22 || bus4.cnt !== 3'd4) begin errors++; $display("FAIL stall_resume: got %h cnt %0d want 22 cnt 4", bus4.q_last, bus4.cnt); end
        for (int t = 0; t < DEPTH; t++) begin
            bus4.sel = 2'(t); #1;
            e = tap_exp(t);
            checks++; if (bus4.q !== e[7:0]) begin errors++; $display("FAIL resume_tap%0d: got %h want %h", t, bus4.q, e[7:0]); end
        end
    endtask

    task automatic test_tap_select();
        logic [7:0] want [4];
        logic [8:0] e;
        want = '{8'h44, 8'h33, 8'h22, 8'h11};
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h11, 1'b1);
        step(1'b1, 1'b0, 8'h22, 1'b1);
        step(1'b1, 1'b0, 8'h33, 1'b1);
        step(1'b1, 1'b0, 8'h44, 1'b1);
        for (int t = 0; t < DEPTH; t++) begin
            bus4.sel = 2'(t); #1;
            e = tap_exp(t);
            checks++; if (bus4.q !== want[t] || bus4.q !== e[7:0]) begin errors++; $display("FAIL tap_sel%0d: got %h want %h", t, bus4.q, want[t]); end
        end
        // Three-deep instance: sel=3 must clamp to the final stage.
        bus3.en = 1'b1; bus3.vld_in = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus3.d_in = 8'(i);
            @(posedge clk); #1;
        end
        bus3.en = 1'b0;
        bus3.sel = 2'd3; #1;
        checks++; if (bus3.q !== 8'h01 || bus3.vld_out !== 1'b1) begin errors++; $display("FAIL clamp_sel3: got %h/%b want 01/1", bus3.q, bus3.vld_out); end
        bus3.sel = 2'd0; #1;
        checks++; if (bus3.q !== 8'h03) begin errors++; $display("FAIL d3_sel0: got %h want 03", bus3.q); end
        checks++; if (bus3.q_last !== 8'h01 || bus3.cnt !== 2'd3) begin errors++; $display("FAIL d3_last: got %h cnt %0d want 01 cnt 3", bus3.q_last, bus3.cnt); end
    endtask

    task automatic test_clear();
        logic [8:0] e;
        step(1'b1, 1'b0, 8'hAA, 1'b1);
        step(1'b1, 1'b0, 8'hBB, 1'b1);
        step(1'b1, 1'b1, 8'hFF, 1'b1);
        checks++; if (bus4.cnt !== 3'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", bus4.cnt); end
        for (int t = 0; t < DEPTH; t++) begin
            bus4.sel = 2'(t); #1;
            checks++; if (bus4.q !== RST4 || bus4.vld_out !== 1'b0) begin errors++; $display("FAIL clr_tap%0d: got %h/%b want %h/0", t, bus4.q, bus4.vld_out, RST4); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            e = sb[0];
            checks++; if (bus4.q_last !== e[7:0] || bus4.vld_last !== 1'b0) begin errors++; $display("FAIL clr_drain%0d: got %h/%b want %h/0", i, bus4.q_last, bus4.vld_last, e[7:0]); end
        end
    endtask

    task automatic test_bubbles();
        logic       pat    [9];
        int         cnt_t  [9];
        logic       vl_t   [9];
        pat   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        cnt_t = '{1, 1, 2, 3, 2, 2, 1, 0, 0};
        vl_t  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        step(1'b0, 1'b1, 8'h00, 1'b0);
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 1'b0, 8'(k + 8'h60), pat[k]);
            checks++; if (int'(bus4.cnt) !== cnt_t[k] || int'(bus4.cnt) !== cnt_exp()) begin errors++; $display("FAIL bub_cnt edge%0d: got %0d want %0d", k + 1, bus4.cnt, cnt_t[k]); end
            checks++; if (bus4.vld_last !== vl_t[k]) begin errors++; $display("FAIL bub_vld_last edge%0d: got %b want %b", k + 1, bus4.vld_last, vl_t[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        logic [8:0] l;
        int         s;
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), 8'($urandom), 1'($urandom));
            s = $urandom_range(0, DEPTH - 1);
            bus4.sel = 2'(s); #1;
            e = tap_exp(s);
            l = sb[0];
            checks++; if (bus4.q !== e[7:0] || bus4.vld_out !== e[8]) begin errors++; $display("FAIL b2b_tap%0d step%0d: got %h/%b want %h/%b", s, i, bus4.q, bus4.vld_out, e[7:0], e[8]); end
            checks++; if (bus4.q_last !== l[7:0] || bus4.vld_last !== l[8]) begin errors++; $display("FAIL b2b_last step%0d: got %h/%b want %h/%b", i, bus4.q_last, bus4.vld_last, l[7:0], l[8]); end
            checks++; if (int'(bus4.cnt) !== cnt_exp()) begin errors++; $display("FAIL b2b_cnt step%0d: got %0d want %0d", i, bus4.cnt, cnt_exp()); end
        end
    endtask

    initial begin
        bus4.en = 1'b0; bus4.clr = 1'b0; bus4.d_in = '0; bus4.vld_in = 1'b0; bus4.sel = '0;
        bus3.en = 1'b0; bus3.clr = 1'b0; bus3.d_in = '0; bus3.vld_in = 1'b0; bus3.sel = '0;
        sb_clear();
        test_reset();
        test_midstream_reset();
        test_latency();
        test_stall();
        test_tap_select();
        test_clear();
        test_bubbles();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
